// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned CNT_WIDTH      = 4;

  typedef enum logic {
    PIPE_PRI = 1'b0,
    FORCE_B  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_register.sv
// Generic enable-gated register with synchronous active-high clear.
module register #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [width-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline WB (A) and mul/div (B),
// with starvation forcing for B and a registered write port.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned width        = DEF_WIDTH,
  parameter int unsigned addr_width   = DEF_ADDR_WIDTH,
  parameter int unsigned starve_limit = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [addr_width-1:0] a_addr,
  input  logic [width-1:0]      a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [addr_width-1:0] b_addr,
  input  logic [width-1:0]      b_data,
  output logic                  b_ready,
  output logic                  rf_we,
  output logic [addr_width-1:0] rf_addr,
  output logic [width-1:0]      rf_data,
  output logic                  b_starving
);

  localparam int unsigned          OUT_W = 1 + addr_width + width;
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(starve_limit);

  arb_state_e            r_state, w_state_next;
  grant_e                w_grant;
  logic                  w_collide;
  logic [CNT_WIDTH-1:0]  r_wait_cnt, w_wait_cnt_next;
  logic                  r_starving;
  logic                  r_fresh;
  logic [addr_width-1:0] w_sel_addr;
  logic [width-1:0]      w_sel_data;
  logic                  w_sel_we;
  logic [OUT_W-1:0]      w_stage_d, w_stage_q;

  // Same nonzero destination: B is the older instruction, so it writes first and A lands last.
  assign w_collide = a_valid && b_valid && (a_addr == b_addr) && (a_addr != '0);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst) begin
      if (w_collide)                           w_grant = GNT_B;
      else if (r_state == FORCE_B && b_valid)  w_grant = GNT_B;
      else if (a_valid)                        w_grant = GNT_A;
      else if (b_valid)                        w_grant = GNT_B;
    end
  end

  assign a_ready = (w_grant == GNT_A);
  assign b_ready = (w_grant == GNT_B);

  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    w_state_next    = r_state;
    if (!b_valid || b_ready)   w_wait_cnt_next = '0;
    else if (r_wait_cnt < LIMIT) w_wait_cnt_next = r_wait_cnt + 1'b1;

    case (r_state)
      PIPE_PRI: if (w_wait_cnt_next == LIMIT) w_state_next = FORCE_B;
      FORCE_B:  if (b_ready || !b_valid)      w_state_next = PIPE_PRI;
      default:  w_state_next = PIPE_PRI;
    endcase
  end

  // NOTE: only control state is reset here; the datapath register gets its own clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PIPE_PRI;
      r_wait_cnt <= '0;
      r_starving <= 1'b0;
      r_fresh    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_starving <= (w_wait_cnt_next == LIMIT);
      r_fresh    <= (w_grant != GNT_NONE);
    end
  end

  assign w_sel_addr = (w_grant == GNT_B) ? b_addr : a_addr;
  assign w_sel_data = (w_grant == GNT_B) ? b_data : a_data;
  assign w_sel_we   = (w_grant != GNT_NONE) && (w_sel_addr != '0);

  // A $0 grant completes the handshake but reloads the held address/data with we=0.
  assign w_stage_d = w_sel_we ? {1'b1, w_sel_addr, w_sel_data}
                              : {1'b0, rf_addr, rf_data};

  register #(.width(OUT_W)) u_out_stage (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_grant != GNT_NONE),
    .i_d  (w_stage_d),
    .o_q  (w_stage_q)
  );

  assign rf_we      = r_fresh & w_stage_q[OUT_W-1];
  assign rf_addr    = w_stage_q[width +: addr_width];
  assign rf_data    = w_stage_q[width-1:0];
  assign b_starving = r_starving;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter; expected regfile writes go through a scoreboard queue.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        b_starving;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .b_starving (b_starving)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive after the edge, check readies/flags mid-cycle, queue the expected write.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ear, input logic ebr, input logic est,
                      input logic chk, input logic ewe, input logic [31:0] edata);
    @(posedge clk);
    #1;
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #3;
    n_vec++;
    check($sformatf("a_ready[v%0d]", n_vec), 32'(a_ready), 32'(ear));
    check($sformatf("b_ready[v%0d]", n_vec), 32'(b_ready), 32'(ebr));
    check($sformatf("b_starving[v%0d]", n_vec), 32'(b_starving), 32'(est));
    if (chk) begin
      check($sformatf("rf_we[v%0d]", n_vec), 32'(rf_we), 32'(ewe));
      check($sformatf("rf_data[v%0d]", n_vec), rf_data, edata);
    end
    if (ear && av && aa != 5'd0) exp_q.push_back('{addr: aa, data: ad});
    if (ebr && bv && ba != 5'd0) exp_q.push_back('{addr: ba, data: bd});
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write @%0t: addr=%0d data=0x%0h, none expected", $time, rf_addr, rf_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_addr", 32'(rf_addr), 32'(e.addr));
        check("sb_data", rf_data, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

    // Reset held with both requesters active.
    step(1, 1, 5'd3, 32'h1,  1, 5'd4, 32'hAA,   0, 0, 0, 1, 0, 32'h0);
    step(1, 1, 5'd3, 32'h1,  1, 5'd4, 32'hAA,   0, 0, 0, 1, 0, 32'h0);
    step(0, 1, 5'd3, 32'h2,  0, 5'd0, 32'h0,    1, 0, 0, 1, 0, 32'h0);
    // Contention: A wins 4 cycles, then B is forced.
    step(0, 1, 5'd5, 32'h50, 1, 5'd7, 32'hBEEF, 1, 0, 0, 1, 1, 32'h2);
    step(0, 1, 5'd5, 32'h51, 1, 5'd7, 32'hBEEF, 1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 5'd5, 32'h52, 1, 5'd7, 32'hBEEF, 1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 5'd5, 32'h53, 1, 5'd7, 32'hBEEF, 1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 5'd5, 32'h54, 1, 5'd7, 32'hBEEF, 0, 1, 1, 1, 1, 32'h53);
    step(0, 1, 5'd5, 32'h55, 0, 5'd0, 32'h0,    1, 0, 0, 1, 1, 32'hBEEF);
    // Collision on r9: B first, A last.
    step(0, 1, 5'd9, 32'h11, 1, 5'd9, 32'h22,   0, 1, 0, 1, 1, 32'h55);
    step(0, 1, 5'd9, 32'h11, 0, 5'd0, 32'h0,    1, 0, 0, 1, 1, 32'h22);
    // Writes to $0: accepted, no rf_we, no collision priority.
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 1, 0, 0, 1, 1, 32'h11);
    step(0, 1, 5'd0, 32'hEEEE, 1, 5'd0, 32'h1234,   1, 0, 0, 1, 0, 32'h11);
    step(0, 0, 5'd0, 32'h0,    1, 5'd0, 32'h1234,   0, 1, 0, 1, 0, 32'h11);
    // Drive into FORCE_B, then reset mid-arbitration.
    step(0, 1, 5'd6, 32'h60, 1, 5'd8, 32'h77,   1, 0, 0, 1, 0, 32'h11);
    step(0, 1, 5'd6, 32'h61, 1, 5'd8, 32'h77,   1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 5'd6, 32'h62, 1, 5'd8, 32'h77,   1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 5'd6, 32'h63, 1, 5'd8, 32'h77,   1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 5'd6, 32'h64, 1, 5'd8, 32'h77,   0, 0, 1, 1, 1, 32'h63);
    step(0, 1, 5'd6, 32'h65, 1, 5'd8, 32'h77,   1, 0, 0, 1, 0, 32'h0);
    // Idle: nothing written, data holds, no starvation.
    step(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 0, 0, 1, 1, 32'h65);
    step(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 0, 0, 1, 0, 32'h65);
    step(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 0, 0, 1, 0, 32'h65);
    // Lone B is always ready.
    step(0, 0, 5'd0, 32'h0,  1, 5'd8, 32'h77,   0, 1, 0, 1, 0, 32'h65);
    step(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    0, 0, 0, 1, 1, 32'h77);

    repeat (3) @(posedge clk);
    #4;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
